// File: rtl/operand_load_arbiter.sv
// operand_load_arbiter: round-robin loader of operand pairs into the shared A/B register file
module operand_load_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int TCNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rf_write_enable,
   output logic [DATA_W-1:0] rf_data_in_A,
   output logic [DATA_W-1:0] rf_data_in_B,
   output logic              op_valid,
   input  logic              op_done,
   output logic              grant_id,
   output logic              busy,
   output logic              timeout
);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
   localparam logic [TCNT_W-1:0] LIMIT = TCNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   state_t              state_q;
   logic                last_grant_q, grant_id_q, we_q, valid_q, busy_q, timeout_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic [TCNT_W-1:0]   cnt_q;
   logic                pick, expired;
   // round-robin pick: contested requests go to whoever did not win last
   always_comb begin
      pick      = (&req_valid) ? ~last_grant_q : req_valid[1];
      req_ready = (state_q == IDLE && |req_valid) ? (pick ? 2'b10 : 2'b01) : 2'b00;
      expired   = (TIMEOUT != 0) && (cnt_q == LIMIT);
   end
   // control FSM with registered outputs; done beats a simultaneous watchdog expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         we_q         <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         cnt_q        <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: if (|req_ready) begin
               a_q          <= pick ? req1_a : req0_a;
               b_q          <= pick ? req1_b : req0_b;
               grant_id_q   <= pick;
               last_grant_q <= pick;
               we_q         <= 1'b1;
               busy_q       <= 1'b1;
               state_q      <= LOAD;
            end
            LOAD: begin
               we_q    <= 1'b0;
               valid_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: if (op_done || expired) begin
               valid_q   <= 1'b0;
               busy_q    <= 1'b0;
               timeout_q <= ~op_done;
               state_q   <= IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign rf_write_enable = we_q;
   assign rf_data_in_A    = a_q;
   assign rf_data_in_B    = b_q;
   assign op_valid        = valid_q;
   assign grant_id        = grant_id_q;
   assign busy            = busy_q;
   assign timeout         = timeout_q;
endmodule

// File: tb/tb_operand_load_arbiter.sv
// tb_operand_load_arbiter: directed checks of arbitration, load timing, watchdog and reset
module tb_operand_load_arbiter;
   logic       clk = 1'b0, rst = 1'b1;
   logic [1:0] req_valid = 2'b00, req_ready;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       rf_write_enable, op_valid, grant_id, busy, timeout;
   logic       op_done = 1'b0;
   logic [7:0] rf_data_in_A, rf_data_in_B, rf_a, rf_b;
   int         passed = 0, total = 0, cyc = 0, last_acc, n;
   logic       exp_g;

   operand_load_arbiter #(.DATA_W(8), .TIMEOUT(4), .TCNT_W(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rf_write_enable(rf_write_enable), .rf_data_in_A(rf_data_in_A), .rf_data_in_B(rf_data_in_B),
      .op_valid(op_valid), .op_done(op_done), .grant_id(grant_id), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // register file the arbiter feeds
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_a <= '0;
         rf_b <= '0;
      end else if (rf_write_enable) begin
         rf_a <= rf_data_in_A;
         rf_b <= rf_data_in_B;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_opv"}, op_valid, 0);
      chk({tag, "_we"}, rf_write_enable, 0);
      chk({tag, "_to"}, timeout, 0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      #1;
      idle_outs("rst");
      chk("rst_gid", grant_id, 0);
      chk("rst_dA", rf_data_in_A, 8'h00);
      chk("rst_dB", rf_data_in_B, 8'h00);
      chk("rst_ready", req_ready, 2'b00);
      // single request from requester 0
      req_valid = 2'b01; req0_a = 8'h3C; req0_b = 8'hA5;
      #1;
      chk("t1_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("t1_we", rf_write_enable, 1);
      chk("t1_dA", rf_data_in_A, 8'h3C);
      chk("t1_dB", rf_data_in_B, 8'hA5);
      chk("t1_busy", busy, 1);
      chk("t1_opv_load", op_valid, 0);
      chk("t1_gid", grant_id, 0);
      tick();
      chk("t1_we_off", rf_write_enable, 0);
      chk("t1_opv", op_valid, 1);
      chk("t1_rfA", rf_a, 8'h3C);
      chk("t1_rfB", rf_b, 8'hA5);
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      idle_outs("t1_end");
      chk("t1_gid_hold", grant_id, 0);
      // contention after reset: alternate 0,1,0,1 with 4-cycle spacing
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 2'b11;
      req0_a = 8'h10; req0_b = 8'h11; req1_a = 8'h20; req1_b = 8'h21;
      last_acc = -1;
      for (int i = 0; i < 4; i++) begin
         exp_g = i[0];
         #1;
         chk("rr_ready", req_ready, exp_g ? 2'b10 : 2'b01);
         if (last_acc >= 0) chk("rr_spacing", cyc - last_acc, 4);
         last_acc = cyc;
         tick();
         chk("rr_gid", grant_id, exp_g);
         chk("rr_dA", rf_data_in_A, exp_g ? 8'h20 : 8'h10);
         chk("rr_ready_load", req_ready, 2'b00);
         tick();
         chk("rr_opv", op_valid, 1);
         tick();
         op_done = 1'b1;
         tick();
         op_done = 1'b0;
      end
      req_valid = 2'b00;
      // watchdog expiry, requester 1 waiting during WAIT
      req_valid = 2'b01; req0_a = 8'h55; req0_b = 8'h66;
      #1;
      chk("to_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b10; req1_a = 8'h77; req1_b = 8'h88;
      tick();
      n = 0;
      while (op_valid && n < 10) begin
         n++;
         chk("to_ready_wait", req_ready, 2'b00);
         chk("to_no_pulse", timeout, 0);
         tick();
      end
      chk("to_opv_cycles", n, 4);
      chk("to_pulse", timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_ready_idle", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      chk("to_pulse_end", timeout, 0);
      chk("to_gid", grant_id, 1);
      chk("to_dA", rf_data_in_A, 8'h77);
      // op_done on 4th WAIT cycle wins over expiry
      tick();
      tick();
      tick();
      tick();
      chk("dw_opv", op_valid, 1);
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      idle_outs("dw");
      tick();
      chk("dw_to_later", timeout, 0);
      // reset mid-WAIT with a pending request from requester 1
      req_valid = 2'b01; req0_a = 8'h11; req0_b = 8'h22;
      tick();
      req_valid = 2'b10; req1_a = 8'h99; req1_b = 8'hAA;
      tick();
      chk("rw_rfA", rf_a, 8'h11);
      chk("rw_rfB", rf_b, 8'h22);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      idle_outs("rw");
      chk("rw_gid", grant_id, 0);
      chk("rw_dA", rf_data_in_A, 8'h00);
      chk("rw_rfA0", rf_a, 8'h00);
      chk("rw_rfB0", rf_b, 8'h00);
      chk("rw_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      chk("rw_gid1", grant_id, 1);
      chk("rw_we", rf_write_enable, 1);
      chk("rw_dB", rf_data_in_B, 8'hAA);
      tick();
      op_done = 1'b1;
      tick();
      // op_done while IDLE is ignored
      tick();
      op_done = 1'b0;
      idle_outs("idle_done");
      chk("idle_done_ready", req_ready, 2'b00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/operand_load_arbiter.md
Name: operand_load_arbiter

Overview:
- Shares the 2-entry operand register file (A/B, 8-bit) between two requesters, e.g. host load path and writeback path.
- Round-robin arbitrates operand-pair requests and drives the register file's write_enable and data inputs for exactly one cycle.
- Presents the loaded pair to the consumer via op_valid/op_done, with a watchdog timeout.
- Sits between the requesters and the register file; the consumer reads the register file outputs directly.

Parameters:
- DATA_W, 8, operand width; matches the register file.
- TIMEOUT, 16, maximum cycles op_valid stays high without op_done; 0 disables the watchdog.
- TCNT_W, 8, width of the watchdog counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-requester request; bit i belongs to requester i
- req_ready  out  2  per-requester accept, one-hot or zero
- req0_a  in  DATA_W  requester 0 operand A
- req0_b  in  DATA_W  requester 0 operand B
- req1_a  in  DATA_W  requester 1 operand A
- req1_b  in  DATA_W  requester 1 operand B
- rf_write_enable  out  1  to the register file's write_enable
- rf_data_in_A  out  DATA_W  to the register file's data_in_A
- rf_data_in_B  out  DATA_W  to the register file's data_in_B
- op_valid  out  1  register file holds a fresh pair for the consumer
- op_done  in  1  consumer finished with the current pair
- grant_id  out  1  requester that owns the current pair
- busy  out  1  FSM not in IDLE
- timeout  out  1  one-cycle pulse, watchdog expired

Behaviour:
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first), all outputs 0, capture regs 0, wait counter 0.
- Reset is synchronous and overrides everything, including mid-LOAD and mid-WAIT. The register file resets on the same rst, so no write is issued.
- States: IDLE, LOAD, WAIT.
- IDLE:
  - req_ready is combinational and only nonzero in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Transfer occurs when req_valid[g] & req_ready[g]. On that edge: capture req{g}_a/b into rf_data_in_A/B, set grant_id=g, last_grant=g, go to LOAD.
  - No valid: stay in IDLE; rf_data_in holds its last value.
- LOAD (exactly 1 cycle):
  - rf_write_enable=1 (registered output, high only in this cycle).
  - Next state WAIT; wait counter cleared to 0.
- WAIT:
  - op_valid=1. The register file contents are the captured pair from the first WAIT cycle onward.
  - op_done=1: go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to IDLE; timeout=1 in the following (IDLE) cycle only.
  - Else: counter+1.
  - op_done and expiry in the same cycle: done wins, no timeout pulse.
- Latency: accept at cycle T; rf_write_enable at T+1; op_valid from T+2. op_done at cycle D returns to IDLE at D+1, where the next accept can occur, i.e. 3-cycle minimum spacing between accepts.
- req_ready=0 in LOAD/WAIT. Requesters hold valid and data stable until accepted. Deasserting valid before acceptance is allowed and not recorded.
- op_done outside WAIT is ignored.
- busy=1 in LOAD and WAIT.
- grant_id holds until the next grant.
- No data transformation: the full DATA_W is passed unchanged.

Test Plan:
- Reset, then req_valid=01, req0_a=0x3C, req0_b=0xA5 -> req_ready=01 at T; rf_write_enable=1 only at T+1 with data 0x3C/0xA5; register file outputs 0x3C/0xA5 and op_valid=1 at T+2; grant_id=0.
- Both valid continuously, op_done pulsed one cycle after each op_valid rise -> grants alternate 0,1,0,1; first grant is requester 0 after reset; accepts spaced 4 cycles apart.
- TIMEOUT=4, op_done never asserted -> op_valid high exactly 4 cycles; timeout pulse 1 cycle; busy drops with it; the next request is accepted in that cycle.
- op_done asserted on the 4th WAIT cycle with TIMEOUT=4 -> return to IDLE, timeout stays 0.
- rst asserted in the WAIT cycle after loading 0x11/0x22 -> next cycle state IDLE, all outputs 0, register file outputs 0x00/0x00; pending req_valid=10 is granted the following cycle.
- op_done pulsed while IDLE, and requester 1 valid while WAIT -> no state change; req_ready stays 00 until return to IDLE.
